// File: rtl/reconfig_addsub_pipe_if.sv
// Operand/result handshake bundle for reconfig_addsub_pipe.
// master drives operands and out_ready; slave is the pipeline.
interface reconfig_addsub_pipe_if #(
    parameter int W     = 16,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             addsuben;
    logic [1:0]       mode;
    logic             sat_en;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     result;
    logic [3:0]       cout;
    logic [3:0]       ovf;
    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid, a, b, addsuben, mode, sat_en, out_ready,
        input  in_ready, out_valid, result, cout, ovf, op_count
    );

    modport slave (
        input  in_valid, a, b, addsuben, mode, sat_en, out_ready,
        output in_ready, out_valid, result, cout, ovf, op_count
    );
endinterface

// File: rtl/reconfig_addsub_pipe.sv
// Lane-split (1/2/4 lanes) add/sub with optional signed saturation; 2-cycle latency.
// Valid/ready on both sides; in_ready drops only when both stages are full and out_ready is low.
module reconfig_addsub_pipe #(
    parameter int W     = 16,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    reconfig_addsub_pipe_if.slave bus
);
    localparam int Q = W / 4;

    logic             s1_vld;
    logic [W-1:0]     s1_a;
    logic [W-1:0]     s1_b;
    logic             s1_sub;
    logic [1:0]       s1_mode;
    logic             s1_sat;

    logic             s2_vld;
    logic [W-1:0]     s2_result;
    logic [3:0]       s2_cout;
    logic [3:0]       s2_ovf;
    logic [CNT_W-1:0] op_cnt;

    logic s2_load;
    logic s1_load;
    logic in_fire;
    logic out_fire;

    assign s2_load  = !s2_vld || bus.out_ready;
    assign s1_load  = !s1_vld || s2_load;
    assign in_fire  = bus.in_valid && s1_load;
    assign out_fire = s2_vld && bus.out_ready;

    assign bus.in_ready  = s1_load;
    assign bus.out_valid = s2_vld;
    assign bus.result    = s2_result;
    assign bus.cout      = s2_cout;
    assign bus.ovf       = s2_ovf;
    assign bus.op_count  = op_cnt;

    // The datapath is four quarter-width slices; mode decides where lanes begin and end.
    function automatic logic lane_start(input logic [1:0] md, input int q);
        if (md == 2'b10) return 1'b1;
        if (md == 2'b01) return (q == 0) || (q == 2);
        return q == 0;
    endfunction

    function automatic logic lane_end(input logic [1:0] md, input int q);
        if (md == 2'b10) return 1'b1;
        if (md == 2'b01) return (q == 1) || (q == 3);
        return q == 3;
    endfunction

    function automatic logic [1:0] lane_id(input logic [1:0] md, input int q);
        if (md == 2'b10) return 2'(q);
        if (md == 2'b01) return 2'(q / 2);
        return 2'd0;
    endfunction

    logic [W-1:0] eb;
    logic [W-1:0] sum_w;
    logic [W-1:0] nxt_result;
    logic [3:0]   lane_cout;
    logic [3:0]   lane_ovf;
    logic [3:0]   lane_neg;
    logic         carry;
    logic [Q:0]   qs;
    logic         a_msb;
    logic         b_msb;
    logic [1:0]   lid;

    always_comb begin
        eb         = s1_b ^ {W{s1_sub}};
        sum_w      = '0;
        nxt_result = '0;
        lane_cout  = '0;
        lane_ovf   = '0;
        lane_neg   = '0;
        carry      = 1'b0;
        qs         = '0;
        a_msb      = 1'b0;
        b_msb      = 1'b0;
        lid        = 2'd0;

        // Carry chains through a slice only when no lane boundary sits there.
        for (int i = 0; i < 4; i++) begin
            if (lane_start(s1_mode, i)) carry = s1_sub;
            qs    = {1'b0, s1_a[i*Q +: Q]} + {1'b0, eb[i*Q +: Q]} + {{Q{1'b0}}, carry};
            carry = qs[Q];
            sum_w[i*Q +: Q] = qs[Q-1:0];
            if (lane_end(s1_mode, i)) begin
                lid   = lane_id(s1_mode, i);
                a_msb = s1_a[i*Q + Q - 1];
                b_msb = eb[i*Q + Q - 1];
                lane_cout[lid] = qs[Q];
                lane_ovf[lid]  = (a_msb == b_msb) && (qs[Q-1] != a_msb);
                lane_neg[lid]  = a_msb;
            end
        end

        // Saturated lane: top slice carries the sign pattern, lower slices fill.
        for (int i = 0; i < 4; i++) begin
            lid = lane_id(s1_mode, i);
            if (s1_sat && lane_ovf[lid]) begin
                if (lane_end(s1_mode, i))
                    nxt_result[i*Q +: Q] = lane_neg[lid] ? {1'b1, {(Q-1){1'b0}}}
                                                         : {1'b0, {(Q-1){1'b1}}};
                else
                    nxt_result[i*Q +: Q] = lane_neg[lid] ? {Q{1'b0}} : {Q{1'b1}};
            end else begin
                nxt_result[i*Q +: Q] = sum_w[i*Q +: Q];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) s1_vld <= 1'b0;
        else if (s1_load) s1_vld <= bus.in_valid;
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_a    <= bus.a;
            s1_b    <= bus.b;
            s1_sub  <= bus.addsuben;
            s1_mode <= bus.mode;
            s1_sat  <= bus.sat_en;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_vld    <= 1'b0;
            s2_result <= '0;
            s2_cout   <= '0;
            s2_ovf    <= '0;
            op_cnt    <= '0;
        end else begin
            if (s2_load) begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    s2_result <= nxt_result;
                    s2_cout   <= lane_cout;
                    s2_ovf    <= lane_ovf;
                end
            end
            if (out_fire) op_cnt <= op_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_reconfig_addsub_pipe.sv
// Randomized and directed bench for reconfig_addsub_pipe against an integer lane model.
module tb_reconfig_addsub_pipe;
    localparam int W     = 16;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [15:0] result;
        logic [3:0]  cout;
        logic [3:0]  ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reconfig_addsub_pipe_if #(.W(W), .CNT_W(CNT_W)) bus ();

    reconfig_addsub_pipe #(.W(W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Each lane computed as plain integers: unsigned for carry, signed for overflow.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic sub,
                                   input logic [1:0] mode, input logic sat);
        exp_t r;
        int lw;
        longint m, half, ua, ub, sa, sb, sr, ur, v;
        r  = '0;
        lw = (mode == 2'b01) ? 8 : (mode == 2'b10) ? 4 : 16;
        m  = longint'(1) << lw;
        half = m / 2;
        for (int l = 0; l < W / lw; l++) begin
            ua = longint'(a >> (l * lw)) & (m - 1);
            ub = longint'(b >> (l * lw)) & (m - 1);
            sa = (ua >= half) ? ua - m : ua;
            sb = (ub >= half) ? ub - m : ub;
            if (sub) begin
                ur = ua - ub;
                r.cout[l] = (ua >= ub);
                sr = sa - sb;
            end else begin
                ur = ua + ub;
                r.cout[l] = (ur >= m);
                sr = sa + sb;
            end
            r.ovf[l] = (sr >= half) || (sr < -half);
            v = ur & (m - 1);
            if (sat && r.ovf[l]) v = (sr > 0) ? half - 1 : half;
            r.result = r.result | 16'(v << (l * lw));
        end
        return r;
    endfunction

    exp_t q[$];
    logic [CNT_W-1:0] exp_cnt;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            exp_cnt = '0;
        end else begin
            exp_t e;
            check("op_count", 32'(bus.op_count), 32'(exp_cnt));
            if (q.size() == 0) check("idle_out_valid", 32'(bus.out_valid), 0);
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                e = q.pop_front();
                check("sb_result", 32'(bus.result), 32'(e.result));
                check("sb_cout", 32'(bus.cout), 32'(e.cout));
                check("sb_ovf", 32'(bus.ovf), 32'(e.ovf));
                exp_cnt = exp_cnt + 1'b1;
            end
            if (bus.in_valid && bus.in_ready)
                q.push_back(model(bus.a, bus.b, bus.addsuben, bus.mode, bus.sat_en));
        end
    end

    task automatic set_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                          input logic [1:0] mode, input logic sat);
        bus.a = a; bus.b = b; bus.addsuben = sub; bus.mode = mode; bus.sat_en = sat;
        bus.in_valid = 1'b1;
    endtask

    // Single operation on an idle pipe, exact 2-cycle latency, controls scrambled after capture.
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic [1:0] mode, input logic sat,
                         input logic [15:0] er, input logic [3:0] ec, input logic [3:0] eo);
        bus.out_ready = 1'b1;
        set_op(a, b, sub, mode, sat);
        #1 check({tag, "_in_ready"}, 32'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.a = ~a; bus.b = ~b; bus.addsuben = ~sub; bus.mode = ~mode; bus.sat_en = ~sat;
        check({tag, "_lat1_valid"}, 32'(bus.out_valid), 0);
        @(posedge clk); #1;
        check({tag, "_lat2_valid"}, 32'(bus.out_valid), 1);
        check({tag, "_result"}, 32'(bus.result), 32'(er));
        check({tag, "_cout"}, 32'(bus.cout), 32'(ec));
        check({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
        @(posedge clk); #1;
    endtask

    logic [15:0] held;
    logic [15:0] specials [4];
    logic        took;
    exp_t        ex;

    initial begin
        specials[0] = 16'h7FFF; specials[1] = 16'h8000;
        specials[2] = 16'hFFFF; specials[3] = 16'h0000;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.addsuben = 1'b0; bus.mode = 2'b00; bus.sat_en = 1'b0;

        #12;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_result", 32'(bus.result), 0);
        check("rst_cout", 32'(bus.cout), 0);
        check("rst_ovf", 32'(bus.ovf), 0);
        check("rst_op_count", 32'(bus.op_count), 0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(bus.in_ready), 1);

        do_op("add1", 16'h00FF, 16'h0001, 1'b0, 2'b00, 1'b0, 16'h0100, 4'b0000, 4'b0000);
        do_op("sub2", 16'h0503, 16'h0207, 1'b1, 2'b01, 1'b0, 16'h03FC, 4'b0010, 4'b0000);
        do_op("add4", 16'h7777, 16'h1111, 1'b0, 2'b10, 1'b0, 16'h8888, 4'b0000, 4'b1111);
        do_op("add4s", 16'h7777, 16'h1111, 1'b0, 2'b10, 1'b1, 16'h7777, 4'b0000, 4'b1111);
        do_op("mode11", 16'hFFFF, 16'h0001, 1'b0, 2'b11, 1'b0, 16'h0000, 4'b0001, 4'b0000);
        do_op("mode00", 16'hFFFF, 16'h0001, 1'b0, 2'b00, 1'b0, 16'h0000, 4'b0001, 4'b0000);
        do_op("sat1neg", 16'h8000, 16'h0001, 1'b1, 2'b00, 1'b1, 16'h8000, 4'b0001, 4'b0001);

        // Backpressure from a fresh reset so op_count should land on exactly 3.
        #2 rst = 1'b1; #2 rst = 1'b0;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        set_op(16'h1234, 16'h1111, 1'b0, 2'b00, 1'b0);
        ex = model(16'h1234, 16'h1111, 1'b0, 2'b00, 1'b0);
        #1 check("bp_x_ready", 32'(bus.in_ready), 1);
        @(posedge clk); #1;
        set_op(16'h4080, 16'h7F01, 1'b1, 2'b01, 1'b0);
        check("bp_y_ready", 32'(bus.in_ready), 1);
        @(posedge clk); #1;
        set_op(16'h7F9A, 16'h2C3D, 1'b0, 2'b10, 1'b1);
        check("bp_z_held", 32'(bus.in_ready), 0);
        check("bp_out_valid", 32'(bus.out_valid), 1);
        check("bp_x_result", 32'(bus.result), 32'(ex.result));
        held = bus.result;
        repeat (3) begin
            @(posedge clk); #1;
            check("bp_stall_ready", 32'(bus.in_ready), 0);
            check("bp_hold_result", 32'(bus.result), 32'(held));
        end
        bus.out_ready = 1'b1;
        #1 check("bp_release_ready", 32'(bus.in_ready), 1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("bp_op_count", 32'(bus.op_count), 3);
        check("bp_drain", 32'(q.size()), 0);

        // Reset with both stages full: nothing from before it may surface.
        bus.out_ready = 1'b0;
        set_op(16'hAAAA, 16'h5555, 1'b0, 2'b01, 1'b0);
        @(posedge clk); #1;
        set_op(16'h0F0F, 16'h0101, 1'b1, 2'b10, 1'b1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("rmid_full_valid", 32'(bus.out_valid), 1);
        #1 rst = 1'b1;
        #1;
        check("rmid_out_valid", 32'(bus.out_valid), 0);
        check("rmid_op_count", 32'(bus.op_count), 0);
        check("rmid_result", 32'(bus.result), 0);
        check("rmid_cout", 32'(bus.cout), 0);
        check("rmid_ovf", 32'(bus.ovf), 0);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("rmid_in_ready", 32'(bus.in_ready), 1);
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("rmid_no_stale", 32'(bus.out_valid), 0);

        // Random traffic with random backpressure; inputs held until accepted.
        took = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (!bus.in_valid || took) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : 16'($urandom);
                bus.b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : 16'($urandom);
                bus.addsuben = 1'($urandom);
                bus.mode = 2'($urandom);
                bus.sat_en = 1'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            took = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 check("rand_drain", 32'(q.size()), 0);
        check("rand_op_count", 32'(bus.op_count), 32'(exp_cnt));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/reconfig_addsub_pipe.md
RECONFIG_ADDSUB_PIPE -- requirements
Module: reconfig_addsub_pipe

Interface
REQ-001 Parameter W, default 16, meaning operand width in bits; SHALL be a multiple of 4 and at least 8.
REQ-002 Parameter CNT_W, default 16, meaning width of the completed-operation counter.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port in_valid  input  1  operand set present.
REQ-006 Port in_ready  output  1  block accepts operands this cycle.
REQ-007 Port a, b  input  W each  operands.
REQ-008 Port addsuben  input  1  0 selects a+b, 1 selects a-b, for all lanes.
REQ-009 Port mode  input  2  lane split: 00 one W-bit lane, 01 two W/2 lanes, 10 four W/4 lanes, 11 same as 00.
REQ-010 Port sat_en  input  1  per-lane signed saturation enable.
REQ-011 Port out_valid  output  1  result present.
REQ-012 Port out_ready  input  1  consumer accepts the result.
REQ-013 Port result  output  W  lane results packed, lane 0 in the LSBs.
REQ-014 Port cout  output  4  per-lane carry-out; bits for unused lanes SHALL be 0.
REQ-015 Port ovf  output  4  per-lane signed overflow; bits for unused lanes SHALL be 0.
REQ-016 Port op_count  output  CNT_W  number of results consumed since reset.

Function
REQ-017 Handshake: a transfer SHALL occur when valid and ready are both high in the same cycle. This applies to both the input and output sides.
REQ-018 Pipeline: two register stages, S1 (captured operands and controls) and S2 (computed result and flags). Latency SHALL be exactly 2 cycles from input transfer to out_valid when there is no backpressure.
REQ-019 Stage advance rules:
- S2 SHALL load when S2 is empty or out_ready is high.
- S1 SHALL load when S1 is empty or S1 advances.
- in_ready SHALL equal S1-empty OR S2-loads; it SHALL be combinational with no dependence on in_valid.
REQ-020 Full throughput: one transfer per cycle SHALL be sustained while out_ready is held high.
REQ-021 Backpressure: while out_ready is low and both stages are full, in_ready SHALL be low. Held result, cout and ovf SHALL stay stable. No operand SHALL be lost or duplicated, and order SHALL be preserved.
REQ-022 Lane arithmetic: lane width LW is W, W/2 or W/4. Each lane SHALL compute S = a_lane + (b_lane XOR {LW{addsuben}}) + addsuben. Carries SHALL NOT propagate across lane boundaries.
REQ-023 cout[i] SHALL be the carry out of lane i's MSB. For subtraction, cout=1 means no borrow.
REQ-024 ovf[i] SHALL be 1 when a_lane MSB equals the effective-b MSB and the lane sum MSB differs from them.
REQ-025 Saturation: when sat_en=1 and ovf[i]=1, lane i result SHALL be 0111..1 if the a_lane MSB is 0, and 1000..0 otherwise. cout and ovf SHALL be reported unchanged by saturation.
REQ-026 Control capture: mode, addsuben and sat_en SHALL be captured with the operands. Later changes SHALL NOT affect operations already in flight.
REQ-027 op_count SHALL increment by 1 on each output transfer and SHALL wrap to 0 after all-ones.
REQ-028 Simultaneous input and output transfer in one cycle SHALL be legal, with no bubble inserted.

Reset
REQ-029 On rst assertion, regardless of clk, both stages SHALL become empty: out_valid=0, result=0, cout=0, ovf=0, op_count=0.
REQ-030 After rst deassertion, in_ready SHALL be 1. In-flight operations at reset SHALL be discarded, and no output transfer SHALL occur for them.
REQ-031 Operand data registers need not be reset. Only valid flags, outputs and op_count SHALL be reset.

Verification (W=16)
REQ-032 Single-lane add: mode=00, add, a=0x00FF, b=0x0001 -> 2 cycles later out_valid=1, result=0x0100, cout=0000, ovf=0000.
REQ-033 Two-lane subtract: mode=01, sub, a=0x0503, b=0x0207 -> result=0x03FC, cout=0010, ovf=0000.
REQ-034 Four-lane add: mode=10, add, a=0x7777, b=0x1111, with sat_en=0 -> result=0x8888, cout=0000, ovf=1111; with sat_en=1 -> result=0x7777, ovf=1111.
REQ-035 Backpressure: out_ready=0 while ops X, Y, Z are offered back-to-back:
- X and Y are accepted, then in_ready=0 and Z is held.
- After out_ready=1, outputs appear in order X, Y, Z.
- op_count ends at 3.
REQ-036 Reset mid-operation: rst pulsed with both stages full -> out_valid=0 and op_count=0 immediately, in_ready=1 on the next edge, and no stale result appears afterwards.
REQ-037 Mode 11 with a=0xFFFF, b=0x0001, add -> result=0x0000, cout=0001, ovf=0000, identical to mode 00.
